booth_seq_multiplier_32: RTL

- Sequential signed multiplier; the consumer of the bit-pair (radix-4 Booth) recoding stage.
- Scans the multiplier operand Q one bit-pair per clock and selects a partial product of 0, ±M or ±2M of multiplicand M. Shifts the partial product into place and accumulates it into a 64-bit product.
- Drives the HI/LO result pair for the MUL instruction with a start/busy/done handshake to the control unit.

---
 rtl/booth_seq_multiplier_32.sv | 115 +++++++++++
 1 files changed

// File: rtl/booth_seq_multiplier_32.sv
// Sequential signed multiplier using radix-4 Booth recoding.
// Each clock retires one bit-pair of Q and adds a shifted 0/±M/±2M partial product to a 2*WIDTH accumulator.
module booth_seq_multiplier_32 #(
    parameter int WIDTH = 32
) (
    input  logic             in_clk,
    input  logic             in_rst_n,
    input  logic             in_start,
    input  logic [WIDTH-1:0] in_multiplicand,
    input  logic [WIDTH-1:0] in_multiplier,
    output logic             out_busy,
    output logic             out_done,
    output logic [WIDTH-1:0] out_hi,
    output logic [WIDTH-1:0] out_lo
);
    localparam int N  = WIDTH / 2;
    localparam int PW = 2 * WIDTH;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] m_q, m_d;
    logic [WIDTH:0]   qx_q, qx_d;
    logic [PW-1:0]    acc_q, acc_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             done_q, done_d;

    logic [WIDTH+1:0] m_ext;
    logic [WIDTH+1:0] pp;
    logic [PW-1:0]    pp_ext;
    logic [PW-1:0]    acc_next;

    // qx_q holds Q with an implicit zero appended below bit 0, so qx_q[2:0] is always the current triplet.
    always_comb begin
        m_ext = {{2{m_q[WIDTH-1]}}, m_q};
        pp    = '0;
        case (qx_q[2:0])
            3'b001, 3'b010: pp = m_ext;
            3'b011:         pp = m_ext << 1;
            3'b100:         pp = -(m_ext << 1);
            3'b101, 3'b110: pp = -m_ext;
            default:        pp = '0;
        endcase
        pp_ext   = {{(PW-WIDTH-2){pp[WIDTH+1]}}, pp};
        acc_next = acc_q + (pp_ext << {cnt_q, 1'b0});
    end

    always_comb begin
        state_d = state_q;
        m_d     = m_q;
        qx_d    = qx_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        done_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (in_start) begin
                    m_d     = in_multiplicand;
                    qx_d    = {in_multiplier, 1'b0};
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                acc_d = acc_next;
                qx_d  = {{2{qx_q[WIDTH]}}, qx_q[WIDTH:2]};
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(N - 1)) begin
                    hi_d    = acc_next[PW-1:WIDTH];
                    lo_d    = acc_next[WIDTH-1:0];
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge in_clk) begin
        if (!in_rst_n) begin
            state_q <= S_IDLE;
            m_q     <= '0;
            qx_q    <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            m_q     <= m_d;
            qx_q    <= qx_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            done_q  <= done_d;
        end
    end

    assign out_busy = (state_q == S_RUN);
    assign out_done = done_q;
    assign out_hi   = hi_q;
    assign out_lo   = lo_q;

endmodule
